ami_strided_req_gen: RTL and testbench
======================================

# ami_strided_req_gen

Application-side request generator that feeds one AmorphOSMem app port (one `mem_req_in[app][port]` / `mem_resp_out[app][port]` pair). From a single start command it issues a strided burst of `COUNT` write or read requests over the MemReq valid/grant handshake. In read mode it consumes the in-order responses and tracks outstanding requests against a credit limit. It is the synthesizable replacement for hand-written per-port stimulus loops and is used for bring-up and bandwidth tests of the AMI memory system.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 8: maximum issued-but-unanswered reads; range 1..255.
- `CNT_WIDTH`, 16: width of count and progress counters.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a burst; sampled only in IDLE or DONE.
- `cfg_is_write` in 1: 1 = write burst, 0 = read burst.
- `cfg_base_addr` in `AMI_ADDR_WIDTH`: byte address of request 0.
- `cfg_stride` in `AMI_ADDR_WIDTH`: byte increment between requests.
- `cfg_count` in `CNT_WIDTH`: number of requests.
- `cfg_data_seed` in 32: data pattern base.
- `mem_req_out` out MemReq: request to the AMI port (`valid`, `isWrite`, `addr`, `data`).
- `mem_req_grant_in` in 1: AMI accepts `mem_req_out` in this cycle.
- `mem_resp_in` in MemResp: read response from the AMI port.
- `mem_resp_grant_out` out 1: generator consumes `mem_resp_in` in this cycle.
- `busy` out 1: burst in progress.
- `done` out 1: burst complete; held until the next accepted `start` or reset.
- `reqs_issued` out `CNT_WIDTH`: requests accepted in the current burst.
- `resps_received` out `CNT_WIDTH`: read responses consumed in the current burst.
- `mismatch` out 1: sticky read-data mismatch flag (only with the macro below; otherwise tied 0).

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE with `start`=1:
  - Latch all `cfg_*` inputs.
  - Clear both counters and `mismatch`; deassert `done`.
  - Go to ISSUE, or to DONE if `cfg_count`=0.
- ISSUE, request i:
  - `addr` = base + i*stride, computed by a running accumulator, truncated modulo 2^`AMI_ADDR_WIDTH`. The accumulator wrap is silent.
  - `isWrite` = latched mode.
  - `data` = zero-extend(seed + i), the sum taken mod 2^32. Data is driven in read mode too but is don't-care to the AMI.
  - `valid` is asserted while i < count and, in read mode, while outstanding < `MAX_OUTSTANDING`.
  - `valid`, `addr`, `data` and `isWrite` stay stable until the cycle with `mem_req_grant_in`=1. A grant without valid is ignored.
- Each grant with valid: `reqs_issued`++ and i advances.
- Leaving ISSUE after the last grant:
  - Write mode: to DONE.
  - Read mode: to DRAIN if responses are pending, else to DONE.
- Responses:
  - `mem_resp_grant_out` = `mem_resp_in.valid` whenever the burst is a read and `resps_received` < `reqs_issued`.
  - Each consumed response: `resps_received`++ and outstanding--.
  - Responses are in order; response k corresponds to request k.
- Same-cycle grant and response consume: outstanding is unchanged and both counters increment.
- DRAIN → DONE when `resps_received` = count.
- `start` while `busy` is ignored.
- Unsolicited `mem_resp_in.valid` (write burst, or nothing outstanding): not granted; the generator takes no action.

## Timing
- Reset: state IDLE; `mem_req_out` all-zero (valid=0); `mem_resp_grant_out`=0; `busy`=0; `done`=0; counters 0; `mismatch`=0.
- Reset mid-burst aborts the burst immediately. Requests already granted are not tracked; flushing the AMI port is the integrator's duty.
- `start` in cycle t: `busy`=1 and request 0 valid at t+1.
- Sustained grants give one request per cycle with no bubbles.
- Read mode: `mem_resp_grant_out` is combinational from `mem_resp_in.valid` and state. No registered delay is permitted.
- `done` rises the cycle after the last grant (writes) or after the last consumed response (reads). `busy` falls in the same cycle.
- `cfg_count`=0: `done` at t+1; no request is issued.

## Configuration
- `AMI_REQGEN_READ_CHECK_EN`
- Defined:
  - Each consumed read response's `data[31:0]` is compared with seed + k, where k is the response index.
  - Upper data bits must be zero.
  - Any difference sets `mismatch` the cycle after consumption; it stays set until the next `start` or reset.
- Undefined: no comparator; `mismatch` is constant 0.

## Test plan
- Write burst against an AMI model granting every cycle: base 0, stride 128, count 8, seed `h'DEAD0000`.
  - Expect addresses 0,128,…,896 and data `DEAD0000`…`DEAD0007` on consecutive cycles.
  - `done` at t+9.
- Grant withheld 3 cycles on request 2: `mem_req_out` is stable for all 3 cycles; `reqs_issued` stays 2 until the grant.
- Read burst, count 12, `MAX_OUTSTANDING`=4, response latency 10 cycles:
  - `valid` drops after 4 grants and resumes one cycle after each response.
  - `resps_received`=12, then `done`.
- Same-cycle grant and response at outstanding=4: outstanding stays 4 and both counters increment.
- `cfg_count`=0: `done`=1 at t+1; `mem_req_out.valid` never asserted. `start` while busy: no effect on counters.
- `AMI_REQGEN_READ_CHECK_EN`: response 3 of a read burst with seed `h'BEEF0000` returns `BEEF0004`. Expect `mismatch` set the next cycle and still set at `done`.

Source files
------------

// File: rtl/ami_strided_req_gen_if.sv
// AMI app-port request/response channel between a generator and one AmorphOSMem port.
// Master side issues MemReq and consumes MemResp; slave side is the AMI port.
interface ami_strided_req_gen_if #(
    parameter int AMI_ADDR_WIDTH = 64,
    parameter int AMI_DATA_WIDTH = 512
);
    logic                      mem_req_valid;
    logic                      mem_req_is_write;
    logic [AMI_ADDR_WIDTH-1:0] mem_req_addr;
    logic [AMI_DATA_WIDTH-1:0] mem_req_data;
    logic                      mem_req_grant;
    logic                      mem_resp_valid;
    logic [AMI_DATA_WIDTH-1:0] mem_resp_data;
    logic                      mem_resp_grant;

    modport master (
        output mem_req_valid,
        output mem_req_is_write,
        output mem_req_addr,
        output mem_req_data,
        input  mem_req_grant,
        input  mem_resp_valid,
        input  mem_resp_data,
        output mem_resp_grant
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_is_write,
        input  mem_req_addr,
        input  mem_req_data,
        output mem_req_grant,
        output mem_resp_valid,
        output mem_resp_data,
        input  mem_resp_grant
    );
endinterface

// File: rtl/ami_strided_req_gen.sv
// Strided write/read burst generator for one AMI app port, with read credit limit.
// Optional read-data comparator enabled by defining AMI_REQGEN_READ_CHECK_EN.
module ami_strided_req_gen #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int AMI_ADDR_WIDTH  = 64,
    parameter int AMI_DATA_WIDTH  = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cfg_is_write,
    input  logic [AMI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [AMI_ADDR_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]      cfg_count,
    input  logic [31:0]               cfg_data_seed,
    ami_strided_req_gen_if.master     mem,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      reqs_issued,
    output logic [CNT_WIDTH-1:0]      resps_received,
    output logic                      mismatch
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [CNT_WIDTH-1:0] MAX_OUT = CNT_WIDTH'(MAX_OUTSTANDING);

    state_e                    state_q, state_d;
    logic                      is_write_q, is_write_d;
    logic [AMI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AMI_ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic [31:0]               seed_q, seed_d;
    logic [CNT_WIDTH-1:0]      issued_q, issued_d;
    logic [CNT_WIDTH-1:0]      rcvd_q, rcvd_d;

    logic [CNT_WIDTH-1:0] outstanding;
    logic                 active;
    logic                 accept_start;
    logic                 req_valid;
    logic                 req_fire;
    logic                 resp_fire;
    logic [31:0]          req_word;

    always_comb begin
        active       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        outstanding  = issued_q - rcvd_q;
        req_valid    = (state_q == S_ISSUE) &&
                       (is_write_q || (outstanding < MAX_OUT));
        req_fire     = req_valid && mem.mem_req_grant;
        // Response grant stays purely combinational so the AMI sees no extra latency.
        resp_fire    = mem.mem_resp_valid && active && !is_write_q &&
                       (rcvd_q < issued_q);
        req_word     = seed_q + 32'(issued_q);
    end

    assign mem.mem_req_valid    = req_valid;
    assign mem.mem_req_is_write = is_write_q;
    assign mem.mem_req_addr     = addr_q;
    assign mem.mem_req_data     = {{(AMI_DATA_WIDTH-32){1'b0}}, req_word};
    assign mem.mem_resp_grant   = resp_fire;
    assign busy                 = active;
    assign done                 = (state_q == S_DONE);
    assign reqs_issued          = issued_q;
    assign resps_received       = rcvd_q;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        count_d    = count_q;
        seed_d     = seed_q;
        issued_d   = issued_q;
        rcvd_d     = rcvd_q;

        if (resp_fire) begin
            rcvd_d = rcvd_q + 1'b1;
        end
        if (req_fire) begin
            issued_d = issued_q + 1'b1;
            addr_d   = addr_q + stride_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    is_write_d = cfg_is_write;
                    addr_d     = cfg_base_addr;
                    stride_d   = cfg_stride;
                    count_d    = cfg_count;
                    seed_d     = cfg_data_seed;
                    issued_d   = '0;
                    rcvd_d     = '0;
                    state_d    = (cfg_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_fire && (issued_d == count_q)) begin
                    state_d = (is_write_q || (rcvd_d == issued_d)) ?
                              S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rcvd_d == count_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            seed_q     <= '0;
            issued_q   <= '0;
            rcvd_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            seed_q     <= seed_d;
            issued_q   <= issued_d;
            rcvd_q     <= rcvd_d;
        end
    end

`ifdef AMI_REQGEN_READ_CHECK_EN
    logic        mismatch_q, mismatch_d;
    logic [31:0] exp_word;

    always_comb begin
        exp_word   = seed_q + 32'(rcvd_q);
        mismatch_d = mismatch_q;
        if (accept_start) begin
            mismatch_d = 1'b0;
        end else if (resp_fire &&
                     (mem.mem_resp_data !=
                      {{(AMI_DATA_WIDTH-32){1'b0}}, exp_word})) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_resp_data;
    assign unused_resp_data = ^{mem.mem_resp_data, accept_start};
    assign mismatch         = 1'b0;
`endif
endmodule

// File: tb/tb_ami_strided_req_gen.sv
// Randomized bench for ami_strided_req_gen: AMI port model plus a burst-level
// reference model (address = base + i*stride, data = seed + i, in-order responses).
module tb_ami_strided_req_gen;
    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int CW   = 16;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cfg_is_write = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_stride = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [31:0]   cfg_data_seed = '0;
    logic          busy, done, mismatch;
    logic [CW-1:0] reqs_issued, resps_received;

    ami_strided_req_gen_if #(.AMI_ADDR_WIDTH(AW), .AMI_DATA_WIDTH(DW)) mem_if ();

    ami_strided_req_gen #(
        .MAX_OUTSTANDING(MAXO),
        .CNT_WIDTH      (CW),
        .AMI_ADDR_WIDTH (AW),
        .AMI_DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_is_write  (cfg_is_write),
        .cfg_base_addr (cfg_base_addr),
        .cfg_stride    (cfg_stride),
        .cfg_count     (cfg_count),
        .cfg_data_seed (cfg_data_seed),
        .mem           (mem_if.master),
        .busy          (busy),
        .done          (done),
        .reqs_issued   (reqs_issued),
        .resps_received(resps_received),
        .mismatch      (mismatch)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Burst-level reference state
    bit          m_wr;
    logic [AW-1:0] m_base, m_stride;
    logic [31:0] m_seed;
    int          m_cnt, m_i, m_r;
    bit          m_mism;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        mem_if.mem_req_grant  = 1'b1;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data  = '1;
        @(negedge clk);
        chk("rst_valid", mem_if.mem_req_valid, 0);
        chk("rst_iswr", mem_if.mem_req_is_write, 0);
        chk("rst_addr", mem_if.mem_req_addr, 0);
        chk("rst_data", mem_if.mem_req_data, 0);
        chk("rst_rgnt", mem_if.mem_resp_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iss", reqs_issued, 0);
        chk("rst_rcv", resps_received, 0);
        chk("rst_mism", mismatch, 0);
        rst = 1'b0;
        mem_if.mem_req_grant  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = '0;
    endtask

    // gmode: 0 grant always, 1 random grant, 2 withhold 3 cycles on request 2
    task automatic run_burst(input bit wr, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input int cnt,
                             input logic [31:0] seed, input int gmode,
                             input int lat_lo, input int lat_hi, input bit rbp,
                             input int bad, input bit junk, input int abort_at,
                             output int ncyc);
        int            pq_idx[$];
        int            pq_rdy[$];
        int            stall;
        int            k;
        bit            fin, d, vexp, g, rv, rg;
        logic [DW-1:0] rd;
        logic [31:0]   w;
        logic [AW-1:0] a;

        @(negedge clk);
        cfg_is_write  = wr;
        cfg_base_addr = base;
        cfg_stride    = stride;
        cfg_count     = CW'(cnt);
        cfg_data_seed = seed;
        start         = 1'b1;
        m_wr = wr; m_base = base; m_stride = stride; m_cnt = cnt;
        m_seed = seed; m_i = 0; m_r = 0; m_mism = 0;
        fin = 0; ncyc = -1; stall = 0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == abort_at) begin
                fin = 1;
                break;
            end
            d = (m_i == m_cnt) && (m_wr || (m_r == m_cnt));
            chk("busy", busy, !d);
            chk("done", done, d);
            chk("reqs_issued", reqs_issued, m_i);
            chk("resps_received", resps_received, m_r);
            chk("mismatch", mismatch, m_mism);
            if (d && ncyc < 0) ncyc = n;

            if (junk && !d && $urandom_range(0, 7) == 0) begin
                start         = 1'b1;
                cfg_is_write  = 1'($urandom_range(0, 1));
                cfg_base_addr = {$urandom, $urandom};
                cfg_count     = CW'($urandom_range(0, 5));
            end

            vexp = (m_i < m_cnt) && (m_wr || (m_i - m_r) < MAXO);
            case (gmode)
                0: g = 1;
                1: g = ($urandom_range(0, 2) != 0);
                default: begin
                    g = 1;
                    if (vexp && m_i == 2 && stall < 3) begin
                        g = 0;
                        stall++;
                    end
                end
            endcase

            rv = 0;
            rd = '0;
            if (!m_wr && pq_idx.size() > 0 && pq_rdy[0] <= n &&
                (!rbp || $urandom_range(0, 3) != 0)) begin
                k = pq_idx[0];
                w = m_seed + 32'(k);
                if (k == bad) w = w + 32'd1;
                rv = 1;
                rd[31:0] = w;
            end else if ((m_wr || m_r == m_i) && $urandom_range(0, 3) == 0) begin
                rv = 1;
                rd = {16{$urandom}};
            end
            mem_if.mem_req_grant  = g;
            mem_if.mem_resp_valid = rv;
            mem_if.mem_resp_data  = rd;
            #1;

            rg = rv && !m_wr && (m_r < m_i);
            chk("req_valid", mem_if.mem_req_valid, vexp);
            if (vexp) begin
                a = m_base + AW'(m_i) * m_stride;
                w = m_seed + 32'(m_i);
                chk("req_addr", mem_if.mem_req_addr, a);
                chk("req_data", mem_if.mem_req_data, w);
                chk("req_iswr", mem_if.mem_req_is_write, m_wr);
            end
            chk("resp_grant", mem_if.mem_resp_grant, rg);

            if (rg) begin
                w = m_seed + 32'(m_r);
`ifdef AMI_REQGEN_READ_CHECK_EN
                if (rd != {{(DW-32){1'b0}}, w}) m_mism = 1;
`endif
                void'(pq_idx.pop_front());
                void'(pq_rdy.pop_front());
                m_r++;
            end
            if (vexp && g) begin
                if (!m_wr) begin
                    pq_idx.push_back(m_i);
                    pq_rdy.push_back(n + $urandom_range(lat_lo, lat_hi));
                end
                m_i++;
            end
            if (d) begin
                fin = 1;
                break;
            end
        end
        start = 1'b0;
        mem_if.mem_req_grant  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        if (!fin) chk("burst_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        int cnt;
        mem_if.mem_req_grant  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = '0;
        do_reset();

        run_burst(1, '0, 64'd128, 8, 32'hDEAD0000, 0, 1, 1, 0, -1, 0, -1, nc);
        chk("wr8_done_lat", nc, 8);

        run_burst(1, 64'h1000, 64'h40, 6, 32'h1234_5678, 2, 1, 1, 0, -1, 0, -1, nc);
        chk("stall_done_lat", nc, 9);

        run_burst(0, 64'h8000, 64'd64, 12, 32'hCAFE0000, 0, 10, 10, 0, -1, 0, -1, nc);

        run_burst(0, 64'h0, 64'd32, 8, 32'hBEEF0000, 1, 1, 6, 1, 3, 0, -1, nc);

        run_burst(1, 64'h55, 64'h10, 0, 32'h0, 0, 1, 1, 0, -1, 0, -1, nc);
        chk("wr0_done_lat", nc, 0);
        run_burst(0, 64'h55, 64'h10, 0, 32'h0, 0, 1, 1, 0, -1, 0, -1, nc);
        chk("rd0_done_lat", nc, 0);

        run_burst(1, {AW{1'b1}} - 64'd100, 64'd64, 5, 32'hFFFF_FFFE, 0, 1, 1, 0,
                  -1, 0, -1, nc);

        for (int t = 0; t < 12; t++) begin
            cnt = $urandom_range(1, 25);
            run_burst(1'($urandom_range(0, 1)), {$urandom, $urandom},
                      {$urandom, $urandom}, cnt, $urandom, 1, 1, 12, 1,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1,
                      1, -1, nc);
        end

        run_burst(0, 64'h2000, 64'd8, 20, 32'h0A0A0000, 1, 2, 8, 1, -1, 0, 7, nc);
        do_reset();
        run_burst(0, 64'h3000, 64'd16, 10, 32'h0B0B0000, 1, 1, 5, 1, -1, 1, -1, nc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
